// File: rtl/gerenciador_estados.sv
// Pet state controller: samples buttons over fixed windows and moves between
// IDLE, COMENDO, DORMINDO, DANDO_AULA and MORTO, with dwell counter and window tick.
module gerenciador_estados #(
    parameter int W         = 8,
    parameter int JANELA    = 4194304,
    parameter int TIMEOUT   = 16,
    parameter int HAB_MORTE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         b1,
    input  logic         b2,
    input  logic [W-1:0] fome,
    input  logic [W-1:0] felicidade,
    input  logic [W-1:0] sono,
    output logic [3:0]   estado,
    output logic         tick,
    output logic [7:0]   tempo_estado
);

    localparam int CW = $clog2(JANELA);
    localparam logic [7:0] TO_M1 = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE       = 4'b0000,
        DORMINDO   = 4'b0001,
        COMENDO    = 4'b0010,
        DANDO_AULA = 4'b0100,
        MORTO      = 4'b1000
    } estado_t;

    estado_t       r_estado;
    estado_t       w_prox;
    logic [CW-1:0] r_cnt;
    logic          r_p1;
    logic          r_p2;
    logic          r_tick;
    logic [7:0]    r_tempo;
    logic          w_fim;
    logic          w_a1;
    logic          w_a2;
    logic          w_morte;

    assign w_fim   = (r_cnt == CW'(JANELA - 1));
    // a press in the boundary cycle itself still belongs to the closing window
    assign w_a1    = r_p1 | b1;
    assign w_a2    = r_p2 | b2;
    assign w_morte = (HAB_MORTE != 0) &&
                     ((fome == '0) || (felicidade == '0) || (sono == '0));

    always_comb begin
        w_prox = r_estado;
        if (w_morte && (r_estado != MORTO)) begin
            w_prox = MORTO;
        end else begin
            case (r_estado)
                MORTO: begin
                    if (w_a1 && w_a2 && !w_morte) w_prox = IDLE;
                end
                IDLE: begin
                    if (w_a1 && w_a2) w_prox = DANDO_AULA;
                    else if (w_a1)    w_prox = COMENDO;
                    else if (w_a2)    w_prox = DORMINDO;
                end
                COMENDO, DORMINDO, DANDO_AULA: begin
                    if (w_a1 || w_a2)                           w_prox = IDLE;
                    else if ((TIMEOUT != 0) && (r_tempo == TO_M1)) w_prox = IDLE;
                end
                default: w_prox = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_p1     <= 1'b0;
            r_p2     <= 1'b0;
            r_tick   <= 1'b0;
            r_estado <= IDLE;
            r_tempo  <= 8'd0;
        end else begin
            r_tick <= w_fim;
            if (w_fim) begin
                r_cnt    <= '0;
                r_p1     <= 1'b0;
                r_p2     <= 1'b0;
                r_estado <= w_prox;
                if (w_prox != r_estado)  r_tempo <= 8'd0;
                else if (r_tempo != 8'hFF) r_tempo <= r_tempo + 8'd1;
            end else begin
                r_cnt <= r_cnt + CW'(1);
                if (b1) r_p1 <= 1'b1;
                if (b2) r_p2 <= 1'b1;
            end
        end
    end

    assign estado       = r_estado;
    assign tick         = r_tick;
    assign tempo_estado = r_tempo;

endmodule
